// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters.
// A grant is held for a burst of up to MAXBURST words and writes stall while the FIFO is full.
module fifo_write_arbiter #(
   parameter  int NREQ      = 4,
   parameter  int DATAWIDTH = 8,
   parameter  int MAXBURST  = 4,
   localparam int IDW       = $clog2(NREQ)
) (
   input  logic                      wclk,
   input  logic                      wrst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*DATAWIDTH-1:0] req_data,
   output logic [NREQ-1:0]           ack,
   input  logic                      full,
   output logic                      w_en,
   output logic [DATAWIDTH-1:0]      wdata,
   output logic [IDW-1:0]            owner,
   output logic                      busy
);

   localparam int CW = $clog2(MAXBURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state, state_nxt;
   logic [IDW-1:0]       owner_nxt, last, last_nxt, pick;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic                 req_sel, found;
   logic [DATAWIDTH-1:0] data_sel;
   int                   idx;

   // Explicit compare-mux keeps the owner lookup in range even when NREQ is not a power of two.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      req_sel  = 1'b0;
      data_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == IDW'(i)) begin
            req_sel  = req[i];
            data_sel = req_data[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   // First requester after the last owner, wrapping modulo NREQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (idx == j)) begin
               found = 1'b1;
               pick  = IDW'(j);
            end
         end
      end
   end

   assign busy  = (state == BURST);
   assign w_en  = busy & req_sel & ~full;
   assign wdata = busy ? data_sel : '0;

   always_comb begin
      ack = '0;
      for (int i = 0; i < NREQ; i++) begin
         ack[i] = w_en && (owner == IDW'(i));
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (found) begin
               owner_nxt = pick;
               cnt_nxt   = '0;
               state_nxt = BURST;
            end
         end
         BURST: begin
            if (!req_sel) begin
               state_nxt = IDLE;
               last_nxt  = owner;
               cnt_nxt   = '0;
            end else if (w_en) begin
               if (cnt == CW'(MAXBURST - 1)) begin
                  state_nxt = IDLE;
                  last_nxt  = owner;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state <= IDLE;
         owner <= '0;
         last  <= IDW'(NREQ - 1);
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus a randomized run
// checked against a grant/burst reference model.
module tb_fifo_write_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int MB   = 4;
   localparam int IDW  = $clog2(NREQ);

   logic                 wclk = 1'b0;
   logic                 wrst_n = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*DW-1:0]   req_data = '0;
   logic                 full = 1'b0;
   logic [NREQ-1:0]      ack;
   logic                 w_en;
   logic [DW-1:0]        wdata;
   logic [IDW-1:0]       owner;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   logic [NREQ-1:0] prev_ack = '0;

   fifo_write_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .MAXBURST(MB)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .ack(ack),
      .full(full), .w_en(w_en), .wdata(wdata), .owner(owner), .busy(busy)
   );

   always #5 wclk = ~wclk;

   function automatic logic [DW-1:0] slice(input int i);
      return req_data[i*DW +: DW];
   endfunction

   // Drive one cycle of inputs just after the edge; return at the falling edge to sample.
   task automatic apply(input logic [NREQ-1:0] r, input logic f);
      @(posedge wclk);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (prev_ack[i] || !r[i]) req_data[i*DW +: DW] = DW'($urandom);
      req  = r;
      full = f;
      @(negedge wclk);
      prev_ack = ack;
   endtask

   task automatic do_reset();
      req    = '0;
      full   = 1'b0;
      wrst_n = 1'b0;
      prev_ack = '0;
      #3;
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
   endtask

   task automatic test_reset();
      req    = '0;
      full   = 1'b0;
      wrst_n = 1'b0;
      #3;
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b exp 0", w_en); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b exp 0000", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
      checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rst_owner: got %0d exp 0", owner); end
      checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h exp 00", wdata); end
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      apply(4'b0001, 1'b0);
      checks++; if (w_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got w_en=%b busy=%b exp 0 0", w_en, busy); end
      for (int k = 0; k < MB; k++) begin
         apply(4'b0001, 1'b0);
         checks++; if (w_en !== 1'b1 || ack !== 4'b0001) begin errors++; $display("FAIL single_write%0d: got w_en=%b ack=%b exp 1 0001", k, w_en, ack); end
         checks++; if (wdata !== slice(0)) begin errors++; $display("FAIL single_wdata%0d: got %h exp %h", k, wdata, slice(0)); end
      end
      apply(4'b0001, 1'b0);
      checks++; if (busy !== 1'b0 || w_en !== 1'b0) begin errors++; $display("FAIL single_gap: got busy=%b w_en=%b exp 0 0", busy, w_en); end
      apply(4'b0001, 1'b0);
      checks++; if (busy !== 1'b1 || owner !== 2'd0) begin errors++; $display("FAIL single_regrant: got busy=%b owner=%0d exp 1 0", busy, owner); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int g = 0; g < 5; g++) begin
         apply(4'b1111, 1'b0);
         checks++; if (busy !== 1'b0 || w_en !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got busy=%b w_en=%b exp 0 0", g, busy, w_en); end
         for (int k = 0; k < MB; k++) begin
            apply(4'b1111, 1'b0);
            checks++; if (owner !== IDW'(g % NREQ) || ack !== NREQ'(1 << (g % NREQ))) begin
               errors++; $display("FAIL rr_grant%0d_%0d: got owner=%0d ack=%b exp owner=%0d", g, k, owner, ack, g % NREQ);
            end
         end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      apply(4'b0100, 1'b0);
      apply(4'b0100, 1'b0);
      checks++; if (owner !== 2'd2 || ack !== 4'b0100) begin errors++; $display("FAIL stall_first: got owner=%0d ack=%b exp 2 0100", owner, ack); end
      for (int k = 0; k < 5; k++) begin
         apply(4'b0100, 1'b1);
         checks++; if (w_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
            errors++; $display("FAIL stall_hold%0d: got w_en=%b ack=%b busy=%b exp 0 0000 1", k, w_en, ack, busy);
         end
      end
      for (int k = 0; k < MB - 1; k++) begin
         apply(4'b0100, 1'b0);
         checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL stall_resume%0d: got ack=%b exp 0100", k, ack); end
      end
      apply(4'b0100, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end: got busy=%b exp 0", busy); end
   endtask

   task automatic test_drop_wrap();
      do_reset();
      apply(4'b0010, 1'b0);
      apply(4'b0010, 1'b0);
      apply(4'b0010, 1'b0);
      checks++; if (owner !== 2'd1 || ack !== 4'b0010) begin errors++; $display("FAIL drop_write: got owner=%0d ack=%b exp 1 0010", owner, ack); end
      apply(4'b0000, 1'b0);
      checks++; if (ack !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL drop_cycle: got ack=%b busy=%b exp 0000 1", ack, busy); end
      apply(4'b0011, 1'b0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy=%b exp 0", busy); end
      apply(4'b0011, 1'b0);
      checks++; if (owner !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL drop_wrap: got owner=%0d ack=%b exp 0 0001", owner, ack); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      apply(4'b1111, 1'b0);
      apply(4'b1111, 1'b0);
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL midrst_pre: got w_en=%b exp 1", w_en); end
      #2;
      wrst_n = 1'b0;
      #1;
      checks++; if (w_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_drop: got w_en=%b ack=%b busy=%b exp 0 0000 0", w_en, ack, busy);
      end
      req = 4'b0000;
      prev_ack = '0;
      @(posedge wclk);
      #1;
      wrst_n = 1'b1;
      apply(4'b1000, 1'b0);
      apply(4'b1000, 1'b0);
      checks++; if (owner !== 2'd3 || ack !== 4'b1000) begin errors++; $display("FAIL midrst_grant3: got owner=%0d ack=%b exp 3 1000", owner, ack); end
      do_reset();
      apply(4'b1001, 1'b0);
      apply(4'b1001, 1'b0);
      checks++; if (owner !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL midrst_grant0: got owner=%0d ack=%b exp 0 0001", owner, ack); end
   endtask

   // Reference model: tracks who holds the grant and how many words it has written.
   task automatic test_random();
      bit              m_busy = 0;
      int              m_owner = 0;
      int              m_last = NREQ - 1;
      int              m_cnt = 0;
      int              exp_writes = 0;
      int              dut_writes = 0;
      int              first_err = 0;
      logic [NREQ-1:0] r = '0;
      logic            f;
      bit              exp_wen;
      do_reset();
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < NREQ; i++)
            if (r[i] ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0)) r[i] = ~r[i];
         f = ($urandom_range(0, 3) == 0);
         apply(r, f);
         exp_wen = m_busy && r[m_owner] && !f;
         if (w_en) dut_writes++;
         if (exp_wen) exp_writes++;
         checks++;
         if (w_en !== exp_wen || busy !== m_busy || owner !== IDW'(m_owner) ||
             ack !== (exp_wen ? NREQ'(1 << m_owner) : NREQ'(0)) ||
             (exp_wen && wdata !== slice(m_owner)) ||
             (w_en && full) || ((|ack) !== w_en) || !$onehot0(ack)) begin
            errors++;
            if (first_err < 10)
               $display("FAIL rand_cycle%0d: got w_en=%b busy=%b owner=%0d ack=%b wdata=%h exp w_en=%b busy=%b owner=%0d data=%h",
                        n, w_en, busy, owner, ack, wdata, exp_wen, m_busy, m_owner, slice(m_owner));
            first_err++;
         end
         if (!m_busy) begin
            if (r != '0) begin
               for (int k = NREQ; k >= 1; k--)
                  if (r[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
               m_busy = 1;
               m_cnt  = 0;
            end
         end else if (!r[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
         end else if (exp_wen) begin
            m_cnt++;
            if (m_cnt == MB) begin
               m_busy = 0;
               m_last = m_owner;
            end
         end
      end
      checks++; if (dut_writes !== exp_writes) begin errors++; $display("FAIL rand_total: got %0d writes exp %0d", dut_writes, exp_writes); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_drop_wrap();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
